// File: rtl/seg_pkg.sv
// Purpose : shared types, constants and the leading-zero blanking helper for the
//           7-segment scan driver.
// Latency : n/a (types and a pure combinational function only).
// Backpr. : n/a.
package seg_pkg;

    // One display digit as presented to seg_convert2: 0..15 hex, 5'h10 minus,
    // 5'h11..5'h1F passed through for the converter to interpret.
    typedef logic [4:0] seg_val_t;

    localparam seg_val_t SEG_MINUS = 5'h10;

    // Largest supported digit count. lzb_mask works on this fixed width so it
    // can live in the package; callers zero-pad the digits they do not have,
    // which cannot change the result for the digits they do have.
    localparam int MAX_DIG   = 8;
    localparam int MAX_IDX_W = 3;

    typedef logic [MAX_DIG-1:0] dig_mask_t;

    // Bit k set means digit k is a leading zero to be blanked: LZB enabled,
    // k is not the least-significant digit, and digit k plus every digit above
    // it is zero. Minus (SEG_MINUS) and any other nonzero value end the run.
    function automatic dig_mask_t lzb_mask(input seg_val_t [MAX_DIG-1:0] vals,
                                           input logic                   lzb);
        dig_mask_t mask;
        logic      zero_run;
        mask     = '0;
        zero_run = 1'b1;
        for (int k = MAX_DIG - 1; k >= 0; k--) begin
            zero_run = zero_run & (vals[k] == '0);
            mask[k]  = lzb & zero_run & (k != 0);
        end
        return mask;
    endfunction

endpackage

// File: rtl/seg_scan_timer.sv
// Purpose : slot/digit scan timer, frame counter and blink phase generator.
// Latency : next-state values are combinational from the registered state;
//           frame_tick is registered, high on the first cycle of every frame.
// Backpr. : none; free-running, only rst stops it.
//
// Ports:
//   clk, rst      clock and synchronous active-high reset
//   cnt_nxt       slot cycle counter value for the next cycle
//   idx_nxt       digit index for the next cycle
//   phase_nxt     blink phase for the next cycle
//   boundary      high on the last cycle of a frame (snapshot capture point)
//   frame_tick    one-cycle pulse on the first cycle of each frame
module seg_scan_timer #(
    parameter int N_DIG        = 4,
    parameter int SCAN_DIV     = 5000,
    parameter int BLINK_FRAMES = 64,
    parameter int CNT_W        = $clog2(SCAN_DIV),
    parameter int IDX_W        = $clog2(N_DIG)
) (
    input  logic             clk,
    input  logic             rst,
    output logic [CNT_W-1:0] cnt_nxt,
    output logic [IDX_W-1:0] idx_nxt,
    output logic             phase_nxt,
    output logic             boundary,
    output logic             frame_tick
);

    localparam int FCNT_W = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

    localparam logic [CNT_W-1:0]  CNT_MAX  = CNT_W'(SCAN_DIV - 1);
    localparam logic [IDX_W-1:0]  IDX_MAX  = IDX_W'(N_DIG - 1);
    localparam logic [FCNT_W-1:0] FCNT_MAX = FCNT_W'(BLINK_FRAMES - 1);

    logic [CNT_W-1:0]  cnt;
    logic [IDX_W-1:0]  idx;
    logic [FCNT_W-1:0] fcnt;
    logic [FCNT_W-1:0] fcnt_nxt;
    logic              phase;

    always_comb begin
        cnt_nxt   = cnt;
        idx_nxt   = idx;
        fcnt_nxt  = fcnt;
        phase_nxt = phase;
        boundary  = (cnt == CNT_MAX) && (idx == IDX_MAX);

        if (cnt == CNT_MAX) begin
            cnt_nxt = '0;
            idx_nxt = (idx == IDX_MAX) ? '0 : idx + 1'b1;
        end else begin
            cnt_nxt = cnt + 1'b1;
        end

        // Blink phase flips once every BLINK_FRAMES frames, so each half
        // period lasts exactly BLINK_FRAMES frames.
        if (boundary) begin
            if (fcnt == FCNT_MAX) begin
                fcnt_nxt  = '0;
                phase_nxt = ~phase;
            end else begin
                fcnt_nxt = fcnt + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt        <= '0;
            idx        <= '0;
            fcnt       <= '0;
            phase      <= 1'b0;
            frame_tick <= 1'b0;
        end else begin
            cnt        <= cnt_nxt;
            idx        <= idx_nxt;
            fcnt       <= fcnt_nxt;
            phase      <= phase_nxt;
            frame_tick <= boundary;
        end
    end

endmodule

// File: rtl/seg_scan_drv.sv
// Purpose : dynamic-drive scanner for an N_DIG common-anode 7-segment display,
//           feeding one shared seg_convert2 plus active-low digit selects.
// Latency : inputs become visible from the frame after the next frame boundary;
//           all outputs are registers aligned with the internal (cnt, idx).
// Backpr. : none; the display consumes every cycle.
//
// Ports:
//   CLK, RST      clock and synchronous active-high reset
//   DISP_VAL      digit k value at [5k+4:5k], digit N_DIG-1 is the MSD
//   DISP_EN       per-digit enable
//   DISP_DOT      per-digit decimal point
//   DISP_BLINK    per-digit blink enable
//   LZB           leading-zero blanking enable
//   SEG_IN        digit value to the converter
//   SEG_EN        converter enable, 0 turns all segments off
//   DOT           decimal point to the converter
//   DIG_SEL       active-low digit select
//   FRAME_TICK    one-cycle pulse on the first cycle of each frame
module seg_scan_drv #(
    parameter int N_DIG        = 4,
    parameter int SCAN_DIV     = 5000,
    parameter int BLANK_CYC    = 50,
    parameter int BLINK_FRAMES = 64
) (
    input  logic               CLK,
    input  logic               RST,
    input  logic [5*N_DIG-1:0] DISP_VAL,
    input  logic [N_DIG-1:0]   DISP_EN,
    input  logic [N_DIG-1:0]   DISP_DOT,
    input  logic [N_DIG-1:0]   DISP_BLINK,
    input  logic               LZB,
    output logic [4:0]         SEG_IN,
    output logic               SEG_EN,
    output logic               DOT,
    output logic [N_DIG-1:0]   DIG_SEL,
    output logic               FRAME_TICK
);

    import seg_pkg::*;

    localparam int CNT_W = $clog2(SCAN_DIV);
    localparam int IDX_W = $clog2(N_DIG);

    // Frame snapshot: everything the display shows during one frame.
    typedef struct packed {
        seg_val_t [N_DIG-1:0] val;
        logic [N_DIG-1:0]     en;
        logic [N_DIG-1:0]     dot;
        logic [N_DIG-1:0]     blink;
        logic                 lzb;
    } snap_t;

    logic [CNT_W-1:0] cnt_nxt;
    logic [IDX_W-1:0] idx_nxt;
    logic             phase_nxt;
    logic             boundary;

    snap_t snap_q;
    snap_t snap_d;

    seg_val_t [MAX_DIG-1:0] vals_pad;
    dig_mask_t              lzb_blank;

    logic             blank_phase;
    logic             blink_off;
    logic             lzb_hit;
    logic [4:0]       seg_in_d;
    logic             seg_en_d;
    logic             dot_d;
    logic [N_DIG-1:0] dig_sel_d;

    seg_scan_timer #(
        .N_DIG        (N_DIG),
        .SCAN_DIV     (SCAN_DIV),
        .BLINK_FRAMES (BLINK_FRAMES),
        .CNT_W        (CNT_W),
        .IDX_W        (IDX_W)
    ) u_timer (
        .clk        (CLK),
        .rst        (RST),
        .cnt_nxt    (cnt_nxt),
        .idx_nxt    (idx_nxt),
        .phase_nxt  (phase_nxt),
        .boundary   (boundary),
        .frame_tick (FRAME_TICK)
    );

    // Capture on the last cycle of a frame so the whole next frame is drawn
    // from one coherent set of inputs (no tearing from mid-frame updates).
    always_comb begin
        snap_d = snap_q;
        if (boundary) begin
            snap_d.val   = DISP_VAL;
            snap_d.en    = DISP_EN;
            snap_d.dot   = DISP_DOT;
            snap_d.blink = DISP_BLINK;
            snap_d.lzb   = LZB;
        end
    end

    // Decode from next-state values so registered outputs line up with the
    // registered (cnt, idx) of the cycle they are shown in.
    always_comb begin
        vals_pad                = '0;
        vals_pad[N_DIG-1:0]     = snap_d.val;
        lzb_blank               = lzb_mask(vals_pad, snap_d.lzb);
        lzb_hit                 = lzb_blank[MAX_IDX_W'(idx_nxt)];

        // All digits dark at slot start so the previous digit's segments
        // never glow on the newly selected anode.
        blank_phase = (cnt_nxt < CNT_W'(BLANK_CYC));
        blink_off   = phase_nxt & snap_d.blink[idx_nxt];

        seg_in_d  = snap_d.val[idx_nxt];
        dot_d     = snap_d.dot[idx_nxt] & ~blink_off;
        seg_en_d  = ~blank_phase & snap_d.en[idx_nxt] & ~lzb_hit & ~blink_off;
        dig_sel_d = '1;
        if (!blank_phase) begin
            dig_sel_d[idx_nxt] = 1'b0;
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            snap_q  <= '0;
            SEG_IN  <= '0;
            SEG_EN  <= 1'b0;
            DOT     <= 1'b0;
            DIG_SEL <= '1;
        end else begin
            snap_q  <= snap_d;
            SEG_IN  <= seg_in_d;
            SEG_EN  <= seg_en_d;
            DOT     <= dot_d;
            DIG_SEL <= dig_sel_d;
        end
    end

endmodule

// File: tb/tb_seg_scan_drv.sv
// Purpose : scoreboard bench for seg_scan_drv against a cycle-count model.
// Latency : expected outputs are queued per clock and checked 1 time unit later.
// Backpr. : n/a.
module tb_seg_scan_drv;

    localparam int N_DIG   = 4;
    localparam int DIV     = 8;
    localparam int BLANK   = 1;
    localparam int BLINKF  = 2;
    localparam int FRAME   = N_DIG * DIV;

    logic                clk = 1'b0;
    logic                rst = 1'b1;
    logic [5*N_DIG-1:0]  disp_val   = '0;
    logic [N_DIG-1:0]    disp_en    = '0;
    logic [N_DIG-1:0]    disp_dot   = '0;
    logic [N_DIG-1:0]    disp_blink = '0;
    logic                lzb        = 1'b0;
    logic [4:0]          seg_in;
    logic                seg_en;
    logic                dot;
    logic [N_DIG-1:0]    dig_sel;
    logic                frame_tick;

    typedef struct packed {
        logic [4:0]       seg_in;
        logic             seg_en;
        logic             dot;
        logic [N_DIG-1:0] dig_sel;
        logic             tick;
    } out_t;

    out_t exp_q[$];

    int n_check = 0;
    int n_pass  = 0;
    int t       = 0;     // cycles since the reset state, as seen after each edge
    bit started = 1'b0;
    int exp_ticks = 0;
    int dut_ticks = 0;

    // Model snapshot: the inputs that the current frame displays.
    logic [4:0]       m_val [N_DIG];
    logic [N_DIG-1:0] m_en, m_dot, m_blink;
    logic             m_lzb;

    seg_scan_drv #(
        .N_DIG        (N_DIG),
        .SCAN_DIV     (DIV),
        .BLANK_CYC    (BLANK),
        .BLINK_FRAMES (BLINKF)
    ) dut (
        .CLK        (clk),
        .RST        (rst),
        .DISP_VAL   (disp_val),
        .DISP_EN    (disp_en),
        .DISP_DOT   (disp_dot),
        .DISP_BLINK (disp_blink),
        .LZB        (lzb),
        .SEG_IN     (seg_in),
        .SEG_EN     (seg_en),
        .DOT        (dot),
        .DIG_SEL    (dig_sel),
        .FRAME_TICK (frame_tick)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input int act, input int req);
        n_check++;
        if (act == req) n_pass++;
        else $display("FAIL %s: got %h, expected %h (t=%0d)", name, act, req, t);
    endtask

    // Expected display for cycle t of the run, from frame arithmetic.
    function automatic out_t model_out(input int tc, input bit tick);
        out_t o;
        int   cnt, slot, top;
        bit   phase, bl, lz;
        cnt   = tc % DIV;
        slot  = (tc / DIV) % N_DIG;
        phase = bit'(((tc / FRAME) / BLINKF) % 2);
        top   = -1;
        for (int k = 0; k < N_DIG; k++) if (m_val[k] != 0) top = k;
        bl = phase && m_blink[slot];
        lz = m_lzb && (slot > top) && (slot != 0);
        o.seg_in  = m_val[slot];
        o.dot     = m_dot[slot] && !bl;
        o.seg_en  = (cnt >= BLANK) && m_en[slot] && !lz && !bl;
        o.dig_sel = (cnt < BLANK) ? '1 : ~(N_DIG'(1) << slot);
        o.tick    = tick;
        return o;
    endfunction

    // Model: advance on each edge and queue what the DUT should show next.
    initial begin
        bit tick;
        forever begin
            @(posedge clk);
            tick = 1'b0;
            if (rst) begin
                started = 1'b1;
                t = 0;
                for (int k = 0; k < N_DIG; k++) m_val[k] = '0;
                m_en = '0; m_dot = '0; m_blink = '0; m_lzb = 1'b0;
            end else if (started) begin
                if (t % FRAME == FRAME - 1) begin
                    for (int k = 0; k < N_DIG; k++) m_val[k] = disp_val[5*k +: 5];
                    m_en = disp_en; m_dot = disp_dot; m_blink = disp_blink; m_lzb = lzb;
                end
                t++;
                tick = (t % FRAME == 0);
            end
            if (started) begin
                if (tick) exp_ticks++;
                exp_q.push_back(model_out(t, tick));
            end
        end
    end

    // Monitor: every cycle presents a display state; pop and compare.
    initial begin
        out_t e, a;
        forever begin
            @(posedge clk);
            #1;
            if (frame_tick === 1'b1) dut_ticks++;
            if (started) begin
                if (exp_q.size() == 0) begin
                    check("queue_underrun", 0, 1);
                end else begin
                    e = exp_q.pop_front();
                    a = '{seg_in, seg_en, dot, dig_sel, frame_tick};
                    check("outputs", int'(a), int'(e));
                end
            end
        end
    end

    task automatic set_vals(input int d3, input int d2, input int d1, input int d0);
        disp_val = {5'(d3), 5'(d2), 5'(d1), 5'(d0)};
    endtask

    task automatic run_frames(input int n);
        repeat (n * FRAME) @(negedge clk);
    endtask

    // Wait on a negedge where the current frame position equals pos.
    task automatic wait_pos(input int pos);
        for (int i = 0; i < 2 * FRAME; i++) begin
            if (t % FRAME == pos) return;
            @(negedge clk);
        end
        check("wait_pos_timeout", t % FRAME, pos);
    endtask

    initial begin
        int r;
        logic [4:0] v;
        // Reset held three cycles, then a blank first frame.
        repeat (3) @(negedge clk);
        rst = 1'b0;

        // Basic scan.
        set_vals(3, 2, 1, 0);
        disp_en = 4'hF;
        run_frames(3);

        // Leading-zero blanking.
        lzb = 1'b1;
        set_vals(0, 0, 5, 0);        run_frames(2);
        set_vals(0, 0, 0, 0);        run_frames(2);
        set_vals(5'h10, 0, 0, 7);    run_frames(2);

        // Blink with dot on digit 0.
        lzb = 1'b0;
        set_vals(3, 2, 1, 0);
        disp_blink = 4'b0001;
        disp_dot   = 4'b0001;
        run_frames(8);

        // Mid-frame change must wait for the next frame.
        disp_blink = '0;
        set_vals(3, 4, 1, 0);
        run_frames(1);
        wait_pos(5);
        set_vals(3, 9, 1, 0);
        run_frames(2);

        // Randomized inputs changing at arbitrary times, biased toward zeros.
        for (int it = 0; it < 40; it++) begin
            for (int k = 0; k < N_DIG; k++) begin
                r = $urandom_range(0, 7);
                v = (r < 4) ? 5'd0 : (r == 4) ? 5'h10 : 5'($urandom_range(0, 31));
                disp_val[5*k +: 5] = v;
            end
            disp_en    = 4'($urandom);
            disp_dot   = 4'($urandom);
            disp_blink = 4'($urandom);
            lzb        = 1'($urandom);
            repeat ($urandom_range(1, 40)) @(negedge clk);
        end

        // Reset in slot 2 at cnt 4, then one blank frame and normal scanning.
        set_vals(3, 2, 1, 0);
        disp_en = 4'hF; disp_blink = '0; lzb = 1'b0;
        run_frames(1);
        wait_pos(2 * DIV + 4);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        run_frames(3);

        @(negedge clk);
        check("tick_count", dut_ticks, exp_ticks);
        $display("%0d/%0d checks passed", n_pass, n_check);
        $finish;
    end

endmodule
